// File: rtl/display_pkg.sv
// Register map, CTRL/STATUS field positions and blink FSM encoding shared by
// the display MMIO slave.
package display_pkg;

    localparam logic [4:0]  OFF_SEG      = 5'h00;
    localparam logic [4:0]  OFF_LED      = 5'h04;
    localparam logic [4:0]  OFF_CTRL     = 5'h08;
    localparam logic [4:0]  OFF_COMMIT   = 5'h0C;
    localparam logic [4:0]  OFF_STATUS   = 5'h10;
    localparam logic [31:0] WINDOW_BYTES = 32'd20;

    localparam int unsigned CTRL_BLINK_EN_BIT  = 0;
    localparam int unsigned CTRL_AUTO_BIT      = 1;
    localparam int unsigned CTRL_DUR_LSB       = 16;
    localparam int unsigned STATUS_ACTIVE_BIT  = 0;
    localparam int unsigned STATUS_PENDING_BIT = 1;

    typedef enum logic [1:0] {
        BLINK_IDLE  = 2'd0,
        BLINK_TIMED = 2'd1,
        BLINK_HOLD  = 2'd2
    } blink_state_t;

    // CTRL read-back view: unused bits [15:2] always read as zero
    function automatic logic [31:0] pack_ctrl(input logic        blink_en,
                                              input logic        auto_mode,
                                              input logic [15:0] dur_ms);
        logic [31:0] v;
        v = '0;
        v[CTRL_BLINK_EN_BIT]     = blink_en;
        v[CTRL_AUTO_BIT]         = auto_mode;
        v[CTRL_DUR_LSB +: 16]    = dur_ms;
        return v;
    endfunction

endpackage

// File: rtl/ms_tick.sv
// Millisecond prescaler: counts 0..CLK_HZ/1000-1 and pulses tick on the
// terminal count; clear restarts the count from zero.
module ms_tick #(
    parameter int unsigned CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int unsigned DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
    localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] TERMINAL = W'(DIV - 1);

    logic [W-1:0] count;

    assign tick = !clear && (count == TERMINAL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || count == TERMINAL) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/display_mmio.sv
// CPU-bus register slave holding shadow segment/LED values and blink control
// for the seven-segment/LED display driver.
module display_mmio
    import display_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FC60,
    parameter int unsigned CLK_HZ    = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic [23:0] data_display,
    output logic [23:0] led_display,
    output logic        blink_need
);

    logic [31:0]  offset;
    logic [4:0]   reg_off;
    logic         in_window;
    logic         wr_seg, wr_led, wr_ctrl, wr_commit;
    logic [23:0]  seg_shadow, led_shadow;
    logic         pending;
    logic         ctrl_blink_en, ctrl_auto;
    logic [15:0]  ctrl_dur;
    logic [15:0]  ms_left;
    blink_state_t state;
    logic         tick;
    logic [31:0]  rd_val;
    logic         unused_bits;

    // Wrapping subtraction makes addresses below the base land far out of range
    assign offset    = addr - BASE_ADDR;
    assign reg_off   = offset[4:0];
    assign in_window = (offset < WINDOW_BYTES) && (addr[1:0] == 2'b00);

    assign wr_seg    = we && in_window && (reg_off == OFF_SEG);
    assign wr_led    = we && in_window && (reg_off == OFF_LED);
    assign wr_ctrl   = we && in_window && (reg_off == OFF_CTRL);
    assign wr_commit = we && in_window && (reg_off == OFF_COMMIT);

    assign unused_bits = ^{offset[31:5], wdata[15:2]};

    ms_tick #(.CLK_HZ(CLK_HZ)) u_ms_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (wr_ctrl),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_shadow   <= '0;
            led_shadow   <= '0;
            data_display <= '0;
            led_display  <= '0;
            pending      <= 1'b0;
        end else begin
            if (wr_seg) begin
                seg_shadow <= wdata[23:0];
                if (ctrl_auto) data_display <= wdata[23:0];
                else           pending      <= 1'b1;
            end
            if (wr_led) begin
                led_shadow <= wdata[23:0];
                if (ctrl_auto) led_display <= wdata[23:0];
                else           pending     <= 1'b1;
            end
            if (wr_commit) begin
                data_display <= seg_shadow;
                led_display  <= led_shadow;
                pending      <= 1'b0;
            end
        end
    end

    // CTRL register and blink FSM share one block: expiry clears BLINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_blink_en <= 1'b0;
            ctrl_auto     <= 1'b0;
            ctrl_dur      <= '0;
            ms_left       <= '0;
            state         <= BLINK_IDLE;
            blink_need    <= 1'b0;
        end else if (wr_ctrl) begin
            ctrl_blink_en <= wdata[CTRL_BLINK_EN_BIT];
            ctrl_auto     <= wdata[CTRL_AUTO_BIT];
            ctrl_dur      <= wdata[CTRL_DUR_LSB +: 16];
            if (!wdata[CTRL_BLINK_EN_BIT]) begin
                state      <= BLINK_IDLE;
                ms_left    <= '0;
                blink_need <= 1'b0;
            end else if (wdata[CTRL_DUR_LSB +: 16] == 16'd0) begin
                state      <= BLINK_HOLD;
                ms_left    <= '0;
                blink_need <= 1'b1;
            end else begin
                state      <= BLINK_TIMED;
                ms_left    <= wdata[CTRL_DUR_LSB +: 16];
                blink_need <= 1'b1;
            end
        end else if (state == BLINK_TIMED && tick) begin
            if (ms_left <= 16'd1) begin
                state         <= BLINK_IDLE;
                ms_left       <= '0;
                blink_need    <= 1'b0;
                ctrl_blink_en <= 1'b0;
            end else begin
                ms_left <= ms_left - 16'd1;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (reg_off)
            OFF_SEG:    rd_val = {8'd0, seg_shadow};
            OFF_LED:    rd_val = {8'd0, led_shadow};
            OFF_CTRL:   rd_val = pack_ctrl(ctrl_blink_en, ctrl_auto, ctrl_dur);
            OFF_STATUS: begin
                rd_val[STATUS_ACTIVE_BIT]  = blink_need;
                rd_val[STATUS_PENDING_BIT] = pending;
            end
            default:    rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata       <= '0;
            rdata_valid <= 1'b0;
        end else if (re && in_window) begin
            rdata       <= rd_val;
            rdata_valid <= 1'b1;
        end else begin
            rdata_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_display_mmio.sv
// Self-checking bench for display_mmio: directed scenarios plus a randomized
// bus sequence checked against a register-level reference model.
module tb_display_mmio;

    localparam logic [31:0] BASE = 32'hFFFF_FC60;
    localparam int unsigned CYC_PER_MS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic [23:0] data_display;
    logic [23:0] led_display;
    logic        blink_need;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    logic [23:0] m_seg, m_led, m_dd, m_ld;
    logic        m_pend, m_en, m_auto, m_blink;
    logic [15:0] m_dur;
    logic [31:0] m_rdata;

    display_mmio #(.BASE_ADDR(BASE), .CLK_HZ(4000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .addr         (addr),
        .wdata        (wdata),
        .we           (we),
        .re           (re),
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .data_display (data_display),
        .led_display  (led_display),
        .blink_need   (blink_need)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_seg = '0; m_led = '0; m_dd = '0; m_ld = '0;
        m_pend = 0; m_en = 0; m_auto = 0; m_blink = 0; m_dur = '0; m_rdata = '0;
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd20) && (a % 4 == 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a - BASE)
            32'd0:   return {8'd0, m_seg};
            32'd4:   return {8'd0, m_led};
            32'd8:   return {m_dur, 14'd0, m_auto, m_en};
            32'd16:  return {30'd0, m_pend, m_blink};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_write(input logic [31:0] a, input logic [31:0] d);
        case (a - BASE)
            32'd0:  begin m_seg = d[23:0]; if (m_auto) m_dd = m_seg; else m_pend = 1; end
            32'd4:  begin m_led = d[23:0]; if (m_auto) m_ld = m_led; else m_pend = 1; end
            32'd8:  begin m_en = d[0]; m_auto = d[1]; m_dur = d[31:16]; m_blink = d[0]; end
            32'd12: begin m_dd = m_seg; m_ld = m_led; m_pend = 0; end
            default: ;
        endcase
    endtask

    // Callers start aligned to a falling edge; returns one falling edge later
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        if (addr_ok(a)) m_write(a, d);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        d = rdata; v = rdata_valid;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic v;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({data_display, led_display, blink_need, rdata_valid, rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dd=%h ld=%h bn=%b rv=%b rd=%h, want all zero",
                     data_display, led_display, blink_need, rdata_valid, rdata);
        end
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        bus_read(BASE + 32'h10, d, v);
        n_checks++;
        if (v !== 1'b1 || d !== 32'd0) begin
            n_fail++; $display("FAIL reset_status: got v=%b d=%h, want v=1 d=0", v, d);
        end
    endtask

    task automatic test_commit();
        logic [31:0] d; logic v;
        bus_write(BASE + 32'h0, 32'hFF01_2345);
        n_checks++;
        if (data_display !== 24'h0) begin
            n_fail++; $display("FAIL commit_hold: got dd=%h, want 000000", data_display);
        end
        bus_read(BASE + 32'h10, d, v);
        n_checks++;
        if (d !== 32'h2) begin
            n_fail++; $display("FAIL commit_pending: got status=%h, want 00000002", d);
        end
        bus_write(BASE + 32'hC, 32'hDEAD_BEEF);
        n_checks++;
        if (data_display !== 24'h012345 || led_display !== 24'h0) begin
            n_fail++; $display("FAIL commit_apply: got dd=%h ld=%h, want 012345 000000", data_display, led_display);
        end
        bus_read(BASE + 32'h10, d, v);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL commit_clear: got status=%h, want 00000000", d);
        end
    endtask

    task automatic test_auto();
        logic [31:0] d; logic v;
        bus_write(BASE + 32'h8, 32'h0000_0002);
        bus_write(BASE + 32'h4, 32'h0000_A5A5);
        n_checks++;
        if (led_display !== 24'h00A5A5) begin
            n_fail++; $display("FAIL auto_led: got ld=%h, want 00a5a5", led_display);
        end
        bus_read(BASE + 32'h10, d, v);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL auto_pending: got status=%h, want 00000000", d);
        end
        bus_write(BASE + 32'h8, 32'h0);
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp;
        exp = m_read(BASE);
        addr = BASE; wdata = 32'h0077_8899; we = 1'b1; re = 1'b1;
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        m_write(BASE, 32'h0077_8899);
        m_rdata = exp;
        n_checks++;
        if (rdata_valid !== 1'b1 || rdata !== exp) begin
            n_fail++; $display("FAIL same_cycle_read: got v=%b d=%h, want v=1 d=%h", rdata_valid, rdata, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1, d2, d3; logic v1, v2, v3;
        bus_write(BASE + 32'h0, 32'h0011_2233);
        bus_write(BASE + 32'h4, 32'h0044_5566);
        bus_write(BASE + 32'hC, 32'h0);
        bus_read(BASE + 32'h0, d1, v1);
        bus_read(BASE + 32'h4, d2, v2);
        bus_read(BASE + 32'h10, d3, v3);
        m_rdata = d3;
        n_checks++;
        if (data_display !== 24'h112233 || led_display !== 24'h445566) begin
            n_fail++; $display("FAIL b2b_display: got dd=%h ld=%h, want 112233 445566", data_display, led_display);
        end
        n_checks++;
        if ({v1, v2, v3} !== 3'b111 || d1 !== 32'h0011_2233 || d2 !== 32'h0044_5566 || d3 !== 32'h0) begin
            n_fail++; $display("FAIL b2b_reads: got v=%b %h %h %h, want v=111 00112233 00445566 00000000",
                               {v1, v2, v3}, d1, d2, d3);
        end
        @(negedge clk);
        n_checks++;
        if (rdata_valid !== 1'b0 || rdata !== m_rdata) begin
            n_fail++; $display("FAIL b2b_valid_drop: got v=%b d=%h, want v=0 d=%h", rdata_valid, rdata, m_rdata);
        end
    endtask

    task automatic test_window();
        logic [31:0] bad [4];
        logic [31:0] d; logic v;
        bad[0] = BASE + 32'h20; bad[1] = BASE + 32'h1; bad[2] = BASE + 32'h14; bad[3] = BASE - 32'h4;
        for (int i = 0; i < 4; i++) begin
            bus_write(bad[i], 32'h00FF_FFFF);
            bus_write(bad[i] + 32'hC - (bad[i] - BASE) % 4, 32'h0);
            bus_read(bad[i], d, v);
            n_checks++;
            if (v !== 1'b0 || rdata !== m_rdata) begin
                n_fail++; $display("FAIL window_read[%0d]: got v=%b d=%h, want v=0 d=%h", i, v, rdata, m_rdata);
            end
        end
        n_checks++;
        if (data_display !== m_dd || led_display !== m_ld) begin
            n_fail++; $display("FAIL window_display: got dd=%h ld=%h, want %h %h", data_display, led_display, m_dd, m_ld);
        end
        bus_read(BASE, d, v);
        m_rdata = d;
        n_checks++;
        if (d !== {8'd0, m_seg}) begin
            n_fail++; $display("FAIL window_shadow: got seg=%h, want %h", d, {8'd0, m_seg});
        end
    endtask

    task automatic measure_blink(input string name, input int expect_cycles);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 1000 && blink_need === 1'b1; i++) begin
            cnt++;
            @(negedge clk);
        end
        n_checks++;
        if (cnt < expect_cycles - 1 || cnt > expect_cycles + 1) begin
            n_fail++; $display("FAIL %s: blink high %0d cycles, want %0d +/-1", name, cnt, expect_cycles);
        end
        m_en = 0; m_blink = 0;
    endtask

    task automatic test_timed();
        logic [31:0] d; logic v;
        bus_write(BASE + 32'h8, 32'h0003_0001);
        measure_blink("timed_3ms", 3 * CYC_PER_MS);
        bus_read(BASE + 32'h8, d, v);
        m_rdata = d;
        n_checks++;
        if (d !== 32'h0003_0000) begin
            n_fail++; $display("FAIL timed_ctrl_clear: got ctrl=%h, want 00030000", d);
        end
        bus_write(BASE + 32'h8, 32'h0005_0001);
        repeat (7) @(negedge clk);
        n_checks++;
        if (blink_need !== 1'b1) begin
            n_fail++; $display("FAIL timed_mid: got bn=%b, want 1", blink_need);
        end
        bus_write(BASE + 32'h8, 32'h0002_0001);
        measure_blink("timed_restart", 2 * CYC_PER_MS);
    endtask

    task automatic test_hold();
        int lows;
        lows = 0;
        bus_write(BASE + 32'h8, 32'h0000_0001);
        for (int i = 0; i < 10000; i++) begin
            if (blink_need !== 1'b1) lows++;
            @(negedge clk);
        end
        n_checks++;
        if (lows !== 0) begin
            n_fail++; $display("FAIL hold_high: got %0d low cycles, want 0", lows);
        end
        bus_write(BASE + 32'h8, 32'h0);
        n_checks++;
        if (blink_need !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: got bn=%b, want 0", blink_need);
        end
    endtask

    task automatic test_reset_mid_blink();
        logic [31:0] d; logic v;
        bus_write(BASE + 32'h8, 32'h0005_0001);
        bus_write(BASE + 32'h0, 32'h00AB_CDEF);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (blink_need !== 1'b0 || data_display !== 24'h0 || led_display !== 24'h0) begin
            n_fail++; $display("FAIL reset_mid: got bn=%b dd=%h ld=%h, want 0 000000 000000",
                               blink_need, data_display, led_display);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        bus_read(BASE + 32'h10, d, v);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_status: got status=%h, want 00000000", d);
        end
        bus_read(BASE + 32'h0, d, v);
        m_rdata = d;
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_seg: got seg=%h, want 00000000", d);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, rd, exp;
        logic v;
        int op;
        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 9);
            d = $urandom;
            if (op <= 1) bus_write(BASE, d);
            else if (op <= 3) bus_write(BASE + 32'h4, d);
            else if (op == 4) bus_write(BASE + 32'hC, d);
            else if (op == 5) begin
                if (d[0]) d[31:16] = 16'h0;
                bus_write(BASE + 32'h8, d);
            end else if (op <= 8) begin
                a = BASE + 32'($urandom_range(0, 4) * 4);
                exp = m_read(a);
                bus_read(a, rd, v);
                m_rdata = exp;
                n_checks++;
                if (v !== 1'b1 || rd !== exp) begin
                    n_fail++; $display("FAIL rand_read[%0d]: addr=%h got v=%b d=%h, want v=1 d=%h", i, a, v, rd, exp);
                end
            end else begin
                a = BASE + 32'h14 + 32'($urandom_range(0, 40));
                if ($urandom_range(0, 1) == 1) a = BASE + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(1, 3));
                bus_write(a, d);
                bus_read(a, rd, v);
                n_checks++;
                if (v !== 1'b0 || rd !== m_rdata) begin
                    n_fail++; $display("FAIL rand_bad[%0d]: addr=%h got v=%b d=%h, want v=0 d=%h", i, a, v, rd, m_rdata);
                end
            end
            n_checks++;
            if (data_display !== m_dd || led_display !== m_ld || blink_need !== m_blink) begin
                n_fail++; $display("FAIL rand_out[%0d]: got dd=%h ld=%h bn=%b, want %h %h %b",
                                   i, data_display, led_display, blink_need, m_dd, m_ld, m_blink);
            end
        end
        bus_write(BASE + 32'h8, 32'h0);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_commit();
        test_auto();
        test_same_cycle();
        test_back_to_back();
        test_window();
        test_timed();
        test_hold();
        test_reset_mid_blink();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
